// File: rtl/logic_sweep_pkg.sv
// Shared constants for the logic sweep block: FSM encodings and common truth tables.
package logic_sweep_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Truth tables indexed by {a,b}
    localparam logic [3:0] F_AND = 4'b1000;
    localparam logic [3:0] F_XOR = 4'b0110;
    localparam logic [3:0] F_OR  = 4'b1110;
    localparam logic [3:0] F5    = 4'b1101;

endpackage

// File: rtl/lut2_cell.sv
// Single-lane 2-input lookup: the output is the func bit selected by {a,b}.
module lut2_cell (
    input  logic       i_a,
    input  logic       i_b,
    input  logic [3:0] i_func,
    output logic       o_s
);

    assign o_s = i_func[{i_a, i_b}];

endmodule

// File: rtl/logic_sweep.sv
// Sweeps every {a,b} operand pair through a WIDTH-lane 2-input LUT and accumulates
// the population count and XOR signature of all results.
module logic_sweep
    import logic_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    localparam int unsigned CW = 2 * WIDTH + $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [3:0]       i_func,
    output logic             o_vec_valid,
    output logic [WIDTH-1:0] o_vec_a,
    output logic [WIDTH-1:0] o_vec_b,
    output logic [WIDTH-1:0] o_vec_s,
    output logic             o_busy,
    output logic             o_done,
    output logic [CW-1:0]    o_ones_cnt,
    output logic [WIDTH-1:0] o_sig
);

    localparam int unsigned NW = 2 * WIDTH;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [NW-1:0]    r_cnt;
    logic [NW-1:0]    w_cnt_src;
    logic [3:0]       r_func;
    logic             r_mode;
    logic             r_last;
    logic             r_vec_valid;
    logic [WIDTH-1:0] r_vec_a;
    logic [WIDTH-1:0] r_vec_b;
    logic [WIDTH-1:0] w_vec_s;
    logic [WIDTH-1:0] r_sig;
    logic [CW-1:0]    r_ones;
    logic [CW-1:0]    w_pop;
    logic             w_start_ok;
    logic             w_fire;

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign w_cnt_src  = w_start_ok ? '0 : r_cnt;

    // Free-run emits vector 0 on the start edge; r_last blocks the counter wrap.
    assign w_fire = (w_start_ok && !i_mode)
                  || ((r_state == ST_RUN) && !i_abort && !r_last && (!r_mode || i_step));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        lut2_cell u_cell (
            .i_a    (r_vec_a[gi]),
            .i_b    (r_vec_b[gi]),
            .i_func (r_func),
            .o_s    (w_vec_s[gi])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CW'(w_vec_s[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_func      <= '0;
            r_mode      <= 1'b0;
            r_last      <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vec_a     <= '0;
            r_vec_b     <= '0;
            r_ones      <= '0;
            r_sig       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec_valid <= w_fire;
            if (w_start_ok) begin
                r_func <= i_func;
                r_mode <= i_mode;
                r_last <= 1'b0;
                r_ones <= '0;
                r_sig  <= '0;
            end else if (r_vec_valid) begin
                r_ones <= r_ones + w_pop;
                r_sig  <= r_sig ^ w_vec_s;
            end
            if (w_fire) begin
                r_cnt              <= w_cnt_src + NW'(1);
                {r_vec_a, r_vec_b} <= w_cnt_src;
                r_last             <= &w_cnt_src;
            end else if (w_start_ok) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_vec_valid = r_vec_valid;
    assign o_vec_a     = r_vec_a;
    assign o_vec_b     = r_vec_b;
    assign o_vec_s     = w_vec_s;
    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = (r_state == ST_DONE);
    assign o_ones_cnt  = r_ones;
    assign o_sig       = r_sig;

endmodule
